// File: rtl/run_monitor_pkg.sv
// Shared FSM state encoding and run-termination cause codes for run_monitor.
package run_monitor_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CRST = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_CYCLES  = 2'b01;
  localparam logic [1:0] CAUSE_HALT_PC = 2'b10;
  localparam logic [1:0] CAUSE_STALL   = 2'b11;

  // Halt address beats a PC stall, which beats the cycle limit.
  function automatic logic [1:0] pick_cause(input logic halt_hit,
                                            input logic stall_hit,
                                            input logic cycle_hit);
    if (halt_hit)       return CAUSE_HALT_PC;
    else if (stall_hit) return CAUSE_STALL;
    else if (cycle_hit) return CAUSE_CYCLES;
    else                return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/run_trace_fifo.sv
// First-word-fall-through trace FIFO with sticky overflow flag and synchronous clear.
module run_trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             ovf_reg;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign push_ok = push && (!full || pop_ok);

  // Head is read asynchronously so the entry is visible with zero latency.
  assign dout = mem[rd_ptr_reg[AW-1:0]];
  assign ovf  = ovf_reg;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ovf_reg    <= 1'b0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push_ok)         wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)          rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !push_ok) ovf_reg   <= 1'b1;
    end
  end

endmodule

// File: rtl/run_monitor.sv
// Core run supervisor: pulses core reset, times the run, detects halt/stall/limit.
// Define RUN_MONITOR_TRACE_EN to build the PC/IR trace FIFO.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int              PC_W        = 32,
  parameter int              CNT_W       = 32,
  parameter int              MAX_CYCLES  = 2048,
  parameter int              RST_CYCLES  = 2,
  parameter int              STALL_LIMIT = 16,
  parameter logic [PC_W-1:0] HALT_PC     = 32'hFFFF_FFFC,
  parameter int              TRACE_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic [31:0]      ir,
  input  logic             pc_valid,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic [1:0]       done_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  input  logic             trace_rd,
  output logic             trace_empty,
  output logic [PC_W-1:0]  trace_pc,
  output logic [31:0]      trace_ir,
  output logic             trace_ovf
);

  localparam int               STALL_W   = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);
  localparam logic [7:0]       RST_LAST  = 8'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(MAX_CYCLES - 1);

  logic [1:0]         state_reg, state_next;
  logic [7:0]         rst_cnt_reg;
  logic [CNT_W-1:0]   cycle_cnt_reg;
  logic [STALL_W-1:0] stall_reg;
  logic [PC_W-1:0]    prev_pc_reg;
  logic               prev_pc_valid_reg;
  logic [1:0]         cause_reg;
  logic               done_reg;
  logic               core_rst_reg;

  logic in_run, start_ok, halt_hit, stall_hit, cycle_hit;

  assign in_run    = (state_reg == ST_RUN);
  assign start_ok  = start && ((state_reg == ST_IDLE) || (state_reg == ST_HALT));
  assign halt_hit  = in_run && pc_valid && (pc == HALT_PC);
  assign stall_hit = in_run && (stall_reg >= STALL_MAX);
  // Limit is hit on the cycle whose increment brings the count to MAX_CYCLES.
  assign cycle_hit = in_run && (cycle_cnt_reg == CYC_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_HALT: if (start)                       state_next = ST_CRST;
      ST_CRST:          if (rst_cnt_reg == RST_LAST)     state_next = ST_RUN;
      ST_RUN:           if (halt_hit || stall_hit || cycle_hit) state_next = ST_HALT;
      default:                                           state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ST_IDLE;
      rst_cnt_reg       <= '0;
      cycle_cnt_reg     <= '0;
      stall_reg         <= '0;
      prev_pc_reg       <= '0;
      prev_pc_valid_reg <= 1'b0;
      cause_reg         <= CAUSE_NONE;
      done_reg          <= 1'b0;
      core_rst_reg      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      core_rst_reg <= (state_next == ST_CRST);
      if (start_ok) begin
        rst_cnt_reg       <= '0;
        cycle_cnt_reg     <= '0;
        stall_reg         <= '0;
        prev_pc_valid_reg <= 1'b0;
        cause_reg         <= CAUSE_NONE;
        done_reg          <= 1'b0;
      end
      if (state_reg == ST_CRST) rst_cnt_reg <= rst_cnt_reg + 1'b1;
      if (in_run) begin
        if (cycle_cnt_reg != '1) cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
        if (pc_valid) begin
          prev_pc_reg       <= pc;
          prev_pc_valid_reg <= 1'b1;
          // First valid PC of a run has nothing to compare against, so it counts as a change.
          if (prev_pc_valid_reg && (pc == prev_pc_reg))
            stall_reg <= (stall_reg == STALL_MAX) ? stall_reg : stall_reg + 1'b1;
          else
            stall_reg <= '0;
        end
        if (state_next == ST_HALT) begin
          done_reg  <= 1'b1;
          cause_reg <= pick_cause(halt_hit, stall_hit, cycle_hit);
        end
      end
    end
  end

  assign core_rst   = core_rst_reg;
  assign running    = (state_reg == ST_CRST) || in_run;
  assign done       = done_reg;
  assign done_cause = cause_reg;
  assign cycle_cnt  = cycle_cnt_reg;

`ifdef RUN_MONITOR_TRACE_EN
  logic [PC_W+31:0] head;

  run_trace_fifo #(
    .WIDTH (PC_W + 32),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .push  (in_run && pc_valid),
    .pop   (trace_rd),
    .din   ({pc, ir}),
    .dout  (head),
    .empty (trace_empty),
    .ovf   (trace_ovf)
  );

  assign trace_pc = head[PC_W+31:32];
  assign trace_ir = head[31:0];
`else
  localparam int unused_trace_depth = TRACE_DEPTH;
  logic unused_trace_in;
  assign unused_trace_in = ^{trace_rd, ir};

  assign trace_empty = 1'b1;
  assign trace_pc    = '0;
  assign trace_ir    = '0;
  assign trace_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor; trace checks follow RUN_MONITOR_TRACE_EN.
module tb_run_monitor;

  localparam int          PC_W        = 32;
  localparam int          CNT_W       = 32;
  localparam int          MAX_CYCLES  = 2048;
  localparam int          RST_CYCLES  = 2;
  localparam int          STALL_LIMIT = 16;
  localparam int          DEPTH       = 16;
  localparam logic [31:0] HALT_PC     = 32'hFFFF_FFFC;

  logic             clk = 1'b0;
  logic             rst_n, start, pc_valid, trace_rd;
  logic [PC_W-1:0]  pc;
  logic [31:0]      ir;
  logic             core_rst, running, done, trace_empty, trace_ovf;
  logic [1:0]       done_cause;
  logic [CNT_W-1:0] cycle_cnt;
  logic [PC_W-1:0]  trace_pc;
  logic [31:0]      trace_ir;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] sb_q[$];
  logic        exp_ovf;
  logic        got_done;

  run_monitor #(
    .PC_W(PC_W), .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES), .RST_CYCLES(RST_CYCLES),
    .STALL_LIMIT(STALL_LIMIT), .HALT_PC(HALT_PC), .TRACE_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc(pc), .ir(ir), .pc_valid(pc_valid),
    .core_rst(core_rst), .running(running), .done(done), .done_cause(done_cause),
    .cycle_cnt(cycle_cnt), .trace_rd(trace_rd), .trace_empty(trace_empty),
    .trace_pc(trace_pc), .trace_ir(trace_ir), .trace_ovf(trace_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ir_of(input logic [31:0] p);
    return ~p ^ 32'h1357_9BDF;
  endfunction

  // Drive one cycle of inputs; scoreboard pops compare the head before the edge.
  task automatic drive_cycle(input logic [31:0] p, input logic v, input logic rd);
    logic [63:0] e;
    pc = p; ir = ir_of(p); pc_valid = v; trace_rd = rd;
`ifdef RUN_MONITOR_TRACE_EN
    if (rd && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("pop_nonempty", 64'(trace_empty), 64'(0));
      check("pop_pc", 64'(trace_pc), 64'(e[63:32]));
      check("pop_ir", 64'(trace_ir), 64'(e[31:0]));
    end
    if (v) begin
      if (sb_q.size() < DEPTH) sb_q.push_back({p, ir_of(p)});
      else exp_ovf = 1'b1;
    end
`endif
    @(negedge clk);
  endtask

  task automatic start_run();
    int hi;
    hi = 0;
    sb_q.delete();
    exp_ovf = 1'b0;
    pc_valid = 1'b0; trace_rd = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (running && !core_rst) break;
      if (core_rst) hi++;
      @(negedge clk);
    end
    check("crst_len", 64'(hi), 64'(RST_CYCLES));
    check("run_entry", 64'(running && !core_rst), 64'(1));
    check("cnt_start", 64'(cycle_cnt), 64'(0));
    check("done_clr", 64'(done), 64'(0));
    check("cause_clr", 64'(done_cause), 64'(0));
`ifdef RUN_MONITOR_TRACE_EN
    check("fifo_clr", 64'(trace_empty), 64'(1));
    check("ovf_clr", 64'(trace_ovf), 64'(0));
`endif
  endtask

  task automatic end_check(input string tag, input logic [1:0] cause);
    pc_valid = 1'b0;
    check({tag, "_done"}, 64'(got_done), 64'(1));
    check({tag, "_cause"}, 64'(done_cause), 64'(cause));
    check({tag, "_stopped"}, 64'(running), 64'(0));
    $display("run %s: done=%0b cause=%b cycles=%0d", tag, done, done_cause, cycle_cnt);
  endtask

  task automatic drain();
`ifdef RUN_MONITOR_TRACE_EN
    check("ovf_flag", 64'(trace_ovf), 64'(exp_ovf));
    while (sb_q.size() > 0) drive_cycle(32'h0, 1'b0, 1'b1);
    check("drained_empty", 64'(trace_empty), 64'(1));
    drive_cycle(32'h0, 1'b0, 1'b1);
    check("empty_rd_ignored", 64'(trace_empty), 64'(1));
`else
    drive_cycle(32'h0, 1'b0, 1'b1);
    check("notrace_empty", 64'(trace_empty), 64'(1));
    check("notrace_pc", 64'(trace_pc), 64'(0));
    check("notrace_ir", 64'(trace_ir), 64'(0));
    check("notrace_ovf", 64'(trace_ovf), 64'(0));
`endif
    trace_rd = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pc = '0; ir = '0; pc_valid = 1'b0; trace_rd = 1'b0;
    exp_ovf = 1'b0; got_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_core_rst", 64'(core_rst), 64'(1));
    check("rst_running", 64'(running), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_core_rst", 64'(core_rst), 64'(0));
    check("idle_running", 64'(running), 64'(0));
    check("idle_done", 64'(done), 64'(0));
    check("idle_cause", 64'(done_cause), 64'(0));
    check("idle_cnt", 64'(cycle_cnt), 64'(0));
    check("idle_ovf", 64'(trace_ovf), 64'(0));
    check("idle_empty", 64'(trace_empty), 64'(1));

    // Cycle limit with PC stepping by 4.
    start_run();
    got_done = 1'b0;
    for (int k = 0; k < MAX_CYCLES + 10; k++) begin
      drive_cycle(32'(k * 4), 1'b1, 1'b0);
      if (k == 0) check("cnt_first", 64'(cycle_cnt), 64'(1));
      if (done) begin got_done = 1'b1; break; end
    end
    end_check("cycles", 2'b01);
    check("cycles_cnt", 64'(cycle_cnt), 64'(MAX_CYCLES));
    drain();
    check("cnt_hold", 64'(cycle_cnt), 64'(MAX_CYCLES));
    check("done_hold", 64'(done), 64'(1));

    // Halt PC arriving in the same cycle the stall counter sits at its limit.
    start_run();
    for (int k = 0; k < STALL_LIMIT + 1; k++) drive_cycle(32'h40, 1'b1, 1'b0);
    check("no_early_halt", 64'(done), 64'(0));
    drive_cycle(HALT_PC, 1'b1, 1'b0);
    got_done = done;
    end_check("halt_vs_stall", 2'b10);
    drain();

    // PC stuck at 0x40.
    start_run();
    got_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      drive_cycle(32'h40, 1'b1, 1'b0);
      if (done) begin got_done = 1'b1; break; end
    end
    end_check("stall", 2'b11);
    drain();

    // 20 pushes into a 16-deep trace with no reads.
    start_run();
    for (int i = 0; i < 20; i++) drive_cycle(32'h100 + 32'(i * 4), 1'b1, 1'b0);
`ifdef RUN_MONITOR_TRACE_EN
    check("ovf_after_20", 64'(trace_ovf), 64'(1));
    check("head_first_pc", 64'(trace_pc), 64'(32'h100));
`endif
    drive_cycle(HALT_PC, 1'b1, 1'b0);
    got_done = done;
    end_check("overflow", 2'b10);
    drain();

    // Full trace with simultaneous push and pop, halting PC kept.
    start_run();
    for (int i = 0; i < DEPTH; i++) drive_cycle(32'h200 + 32'(i * 4), 1'b1, 1'b0);
    check("full_no_ovf", 64'(trace_ovf), 64'(0));
    for (int i = 0; i < 8; i++) drive_cycle(32'h300 + 32'(i * 4), 1'b1, 1'b1);
    check("pushpop_no_ovf", 64'(trace_ovf), 64'(0));
    drive_cycle(HALT_PC, 1'b1, 1'b1);
    got_done = done;
    end_check("pushpop", 2'b10);
`ifdef RUN_MONITOR_TRACE_EN
    check("pushpop_count", 64'(sb_q.size()), 64'(DEPTH));
`endif
    drain();

    // Reset mid-run aborts without DONE.
    start_run();
    for (int i = 0; i < 5; i++) drive_cycle(32'h500 + 32'(i * 4), 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_core_rst", 64'(core_rst), 64'(1));
    check("abort_running", 64'(running), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1; pc_valid = 1'b0;
    @(negedge clk);
    check("abort_core_rst_low", 64'(core_rst), 64'(0));
    check("abort_cnt", 64'(cycle_cnt), 64'(0));
    check("abort_empty", 64'(trace_empty), 64'(1));
    check("abort_done_after", 64'(done), 64'(0));
    $display("run abort: done=%0b running=%0b", done, running);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
